// File: rtl/axis_wormhole_arbiter_if.sv
// AXI-Stream bundle for the wormhole arbiter: N packed input channels, one output
// channel and the arbitration status. The slave modport is the arbiter's side.
interface axis_wormhole_arbiter_if #(
    parameter int N_INPUTS   = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 4
);
    logic [N_INPUTS-1:0]            in_tvalid_i;
    logic [N_INPUTS*DATA_WIDTH-1:0] in_tdata_i;
    logic [N_INPUTS-1:0]            in_tlast_i;
    logic [N_INPUTS*DEST_WIDTH-1:0] in_tdest_i;
    logic [N_INPUTS-1:0]            in_tready_o;
    logic                           out_tvalid_o;
    logic [DATA_WIDTH-1:0]          out_tdata_o;
    logic                           out_tlast_o;
    logic [DEST_WIDTH-1:0]          out_tdest_o;
    logic                           out_tready_i;
    logic [N_INPUTS-1:0]            grant_o;
    logic                           busy_o;

    modport slave (
        input  in_tvalid_i, in_tdata_i, in_tlast_i, in_tdest_i, out_tready_i,
        output in_tready_o, out_tvalid_o, out_tdata_o, out_tlast_o, out_tdest_o,
        output grant_o, busy_o
    );

    modport master (
        output in_tvalid_i, in_tdata_i, in_tlast_i, in_tdest_i, out_tready_i,
        input  in_tready_o, out_tvalid_o, out_tdata_o, out_tlast_o, out_tdest_o,
        input  grant_o, busy_o
    );
endinterface

// File: rtl/axis_wormhole_arbiter.sv
// Round-robin, packet-locked arbiter sharing one AXI-Stream output between N inputs,
// with a 2-entry output buffer so input ready never depends on output ready.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | no owner; pick the next valid input after last_grant
//   ST_LOCKED | owner streams beats into the buffer until its TLAST is taken
module axis_wormhole_arbiter #(
    parameter int N_INPUTS   = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 4
) (
    input logic                    clk_i,
    input logic                    rst_n_i,
    axis_wormhole_arbiter_if.slave axis
);
    localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int BEAT_W = DATA_WIDTH + DEST_WIDTH + 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [N_INPUTS-1:0] grant_q, grant_d;

    logic [BEAT_W-1:0]   buf_q [2];
    logic                rd_ptr_q, wr_ptr_q;
    logic [1:0]          count_q;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;
    logic                can_push;
    logic                push;
    logic                pop;
    logic [BEAT_W-1:0]   push_beat;
    logic [BEAT_W-1:0]   head;

    // Search starts just after the previous owner so every input gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= N_INPUTS; i++) begin
            cand = IDX_W'((int'(last_grant_q) + i) % N_INPUTS);
            if (!win_found && axis.in_tvalid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // last_grant_q doubles as the owner index while locked.
    assign can_push  = (state_q == ST_LOCKED) && (count_q != 2'd2);
    assign push      = can_push && axis.in_tvalid_i[last_grant_q];
    assign pop       = (count_q != 2'd0) && axis.out_tready_i;
    assign push_beat = {axis.in_tlast_i[last_grant_q],
                        axis.in_tdest_i[last_grant_q*DEST_WIDTH +: DEST_WIDTH],
                        axis.in_tdata_i[last_grant_q*DATA_WIDTH +: DATA_WIDTH]};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(N_INPUTS - 1);
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d          = ST_LOCKED;
                    last_grant_d     = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (push && push_beat[BEAT_W-1]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= push_beat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head              = buf_q[rd_ptr_q];
    assign axis.in_tready_o  = can_push ? grant_q : '0;
    assign axis.out_tvalid_o = (count_q != 2'd0);
    assign axis.out_tlast_o  = head[BEAT_W-1];
    assign axis.out_tdest_o  = head[DATA_WIDTH +: DEST_WIDTH];
    assign axis.out_tdata_o  = head[DATA_WIDTH-1:0];
    assign axis.grant_o      = grant_q;
    assign axis.busy_o       = (state_q == ST_LOCKED);
endmodule
